sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Request-side controller placed directly upstream of one SRAM bank wrapper.
- Turns an OBI-style slave request (byte address, req/gnt, rvalid) into single-port SRAM accesses.
- Runs a zero-fill clear engine after reset or on command.
- Sequences the bank into and out of retention on a sleep handshake from the power manager.

Parameters:
- NumWords, 1024, words in the attached bank; must be at least 2.
- AddrWidth, $clog2(NumWords), derived SRAM word-address width; do not override.
- ClearOnReset, 1, when 1 the bank is zero-filled after every reset; when 0 the block enters ACTIVE directly.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- req_i  in  1  bus request
- gnt_o  out  1  bus grant, combinational
- we_i  in  1  write enable
- addr_i  in  32  byte address; bits [AddrWidth+1:2] select the word
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- clear_start_i  in  1  single-cycle pulse: start a zero-fill
- clear_busy_o  out  1  high while a clear is running
- sleep_req_i  in  1  level: request retention
- sleep_ack_o  out  1  high while the bank is retentive
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_be_o  out  4  SRAM byte enables
- sram_set_retentive_o  out  1  SRAM retention control
- sram_rdata_i  in  32  SRAM read data, valid one cycle after the request

Behaviour:
- States: CLEAR, ACTIVE, DRAIN, RET, WAKE.
- Reset state:
  - State is CLEAR if ClearOnReset=1, otherwise ACTIVE.
  - Clear counter cnt=0.
  - rvalid_o=0, sleep_ack_o=0, sram_set_retentive_o=0.
  - clear_busy_o=ClearOnReset.
- Any reset asserted mid-operation, including mid-clear or in RET, returns to the reset state; a clear restarts from word 0.
- CLEAR:
  - sram_req_o=1, sram_we_o=1, sram_be_o=4'hF, sram_wdata_o=0, sram_addr_o=cnt.
  - cnt increments every cycle.
  - When cnt==NumWords-1, the next state is ACTIVE and cnt returns to 0.
  - Takes exactly NumWords cycles.
  - gnt_o=0, clear_busy_o=1.
  - clear_start_i and sleep_req_i are ignored; sleep is taken once ACTIVE is reached.
- ACTIVE:
  - gnt_o = req_i & ~sleep_req_i & ~clear_start_i.
  - sram_req_o=gnt_o. sram_we_o, sram_be_o and sram_wdata_o pass through from the bus; sram_addr_o=addr_i[AddrWidth+1:2].
  - Addresses beyond NumWords wrap by truncation.
  - Back-to-back grants every cycle are allowed.
- Response:
  - rvalid_o is registered and asserts exactly one cycle after every grant, read or write.
  - rdata_o=sram_rdata_i when rvalid_o is high for a read, otherwise 0.
  - A registered flag records whether the granted access was a write.
- Priority in ACTIVE: sleep_req_i > clear_start_i > req_i.
- Entering CLEAR from ACTIVE:
  - clear_start_i with sleep_req_i low moves to CLEAR at cnt=0.
  - An access granted in the previous cycle still returns its rvalid in the first CLEAR cycle.
- Entering retention from ACTIVE:
  - On sleep_req_i, go to DRAIN if a response is outstanding (rvalid due next cycle), else straight to RET.
  - DRAIN lasts one cycle, then RET.
- RET:
  - sram_set_retentive_o=1, sleep_ack_o=1, sram_req_o=0, gnt_o=0.
  - Stays in RET while sleep_req_i=1.
  - On sleep_req_i=0, move to WAKE.
- WAKE:
  - One cycle with sram_set_retentive_o=0 and sleep_ack_o=1, giving the bank recovery time.
  - gnt_o=0. Then ACTIVE with sleep_ack_o=0.
- sram_set_retentive_o is registered and is never high in the same cycle as sram_req_o.
- Memory contents are not cleared on wake.

Test Plan:
- ClearOnReset=1, NumWords=16, release reset -> sram_req_o/we high for 16 cycles with addresses 0..15, wdata=0, be=F. clear_busy_o then falls and a read of addr 0x3C returns rdata 0.
- Write 0xDEADBEEF to byte address 0x8 with be=4'b0011, then read 0x8 -> gnt in the same cycle, rvalid the next cycle, read data 0x0000BEEF.
- Reads to 0x0, 0x4, 0x8 in three consecutive cycles -> three consecutive rvalid pulses with data in order, no bubbles.
- Read granted, then sleep_req_i raised the next cycle -> one DRAIN cycle, rvalid delivered, then RET with sleep_ack_o=1 and sram_set_retentive_o=1. Drop sleep_req_i -> one WAKE cycle, then a read returns the preserved data.
- req_i, clear_start_i and sleep_req_i all high in ACTIVE -> gnt_o=0 and the block enters RET, not CLEAR.
- Reset asserted at cnt=7 during CLEAR -> the clear restarts at address 0 and completes 16 cycles after reset release.

Source files
------------

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - OBI-style request controller for one SRAM bank with zero-fill clear and retention sequencing
module sram_ctrl #(
    parameter int NumWords     = 1024,
    parameter int AddrWidth    = $clog2(NumWords),
    parameter bit ClearOnReset = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    input  logic                 clear_start_i,
    output logic                 clear_busy_o,
    input  logic                 sleep_req_i,
    output logic                 sleep_ack_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic [3:0]           sram_be_o,
    output logic                 sram_set_retentive_o,
    input  logic [31:0]          sram_rdata_i
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ACTIVE,
        ST_DRAIN,
        ST_RET,
        ST_WAKE
    } state_e;

    localparam state_e ResetState = ClearOnReset ? ST_CLEAR : ST_ACTIVE;
    localparam logic [AddrWidth-1:0] LastWord = AddrWidth'(NumWords - 1);

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   cnt_q, cnt_d;
    logic                   rvalid_q, rvalid_d;
    logic                   was_write_q, was_write_d;
    logic                   ret_q, ret_d;
    logic                   ack_q, ack_d;
    logic                   gnt;

    // Only the word-select bits of the byte address reach the bank.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:AddrWidth+2], addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastWord) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                gnt = req_i & ~sleep_req_i & ~clear_start_i;
                if (sleep_req_i) begin
                    state_d = rvalid_q ? ST_DRAIN : ST_RET;
                end else if (clear_start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: state_d = ST_RET;
            ST_RET:   if (!sleep_req_i) state_d = ST_WAKE;
            ST_WAKE:  state_d = ST_ACTIVE;
            default:  state_d = ST_ACTIVE;
        endcase
        rvalid_d    = gnt;
        was_write_d = gnt & we_i;
        // Retention and acknowledge follow the next state so both are clean flop outputs.
        ret_d       = (state_d == ST_RET);
        ack_d       = (state_d == ST_RET) || (state_d == ST_WAKE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ResetState;
            cnt_q       <= '0;
            rvalid_q    <= 1'b0;
            was_write_q <= 1'b0;
            ret_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rvalid_q    <= rvalid_d;
            was_write_q <= was_write_d;
            ret_q       <= ret_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        if (state_q == ST_CLEAR) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_be_o    = 4'hF;
            sram_wdata_o = '0;
            sram_addr_o  = cnt_q;
        end else begin
            sram_req_o   = gnt;
            sram_we_o    = we_i;
            sram_be_o    = be_i;
            sram_wdata_o = wdata_i;
            sram_addr_o  = addr_i[AddrWidth+1:2];
        end
    end

    assign gnt_o                = gnt;
    assign rvalid_o             = rvalid_q;
    assign rdata_o              = (rvalid_q && !was_write_q) ? sram_rdata_i : 32'h0;
    assign clear_busy_o         = (state_q == ST_CLEAR);
    assign sleep_ack_o          = ack_q;
    assign sram_set_retentive_o = ret_q;

endmodule
